// File: rtl/sp_mem_bidir_pipe_pkg.sv
// Shared defaults, derived widths and parameter legality checks for the
// bidirectional-bus scratch RAM.
package sp_mem_bidir_pipe_pkg;

    localparam int DEF_DATA_W   = 16;
    localparam int DEF_ADDR_W   = 10;
    localparam int DEF_RD_LAT   = 1;
    localparam int DEF_TURN_CYC = 1;

    // Turnaround counter holds at most RD_LAT+TURN_CYC = 4+3 = 7.
    localparam int BUSY_W = 3;
    typedef logic [BUSY_W-1:0] busy_t;
    localparam busy_t BUSY_ZERO = 3'd0;
    localparam busy_t BUSY_ONE  = 3'd1;

    // Number of byte lanes on the data bus.
    function automatic int be_width(input int data_w);
        return data_w / 8;
    endfunction

    function automatic bit data_w_ok(input int data_w);
        return (data_w >= 8) && ((data_w % 8) == 0);
    endfunction

    function automatic bit rd_lat_ok(input int rd_lat);
        return (rd_lat >= 1) && (rd_lat <= 4);
    endfunction

    function automatic bit turn_cyc_ok(input int turn_cyc);
        return (turn_cyc >= 0) && (turn_cyc <= 3);
    endfunction

endpackage

// File: rtl/sp_mem_rd_pipe.sv
// Read-return pipeline: STAGES-deep valid+data shift register. The last
// stage is what the top level puts on the shared bus.
module sp_mem_rd_pipe
    import sp_mem_bidir_pipe_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int STAGES = DEF_RD_LAT
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_valid,
    input  logic [DATA_W-1:0] i_data,
    output logic              o_valid,
    output logic [DATA_W-1:0] o_data
);

    logic [STAGES-1:0] valid_q;
    logic [STAGES-1:0] valid_d;
    logic [DATA_W-1:0] data_q [STAGES];
    logic [DATA_W-1:0] data_d [STAGES];

    // Shift every stage one step towards the output each cycle.
    always_comb begin
        valid_d    = {STAGES{1'b0}};
        valid_d[0] = i_valid;
        data_d[0]  = i_data;
        for (int s = 1; s < STAGES; s++) begin
            valid_d[s] = valid_q[s-1];
            data_d[s]  = data_q[s-1];
        end
    end

    // Stage registers; reset discards anything in flight.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            valid_q <= {STAGES{1'b0}};
            for (int s = 0; s < STAGES; s++) begin
                data_q[s] <= {DATA_W{1'b0}};
            end
        end else begin
            valid_q <= valid_d;
            for (int s = 0; s < STAGES; s++) begin
                data_q[s] <= data_d[s];
            end
        end
    end

    assign o_valid = valid_q[STAGES-1];
    assign o_data  = data_q[STAGES-1];

endmodule

// File: rtl/sp_mem_bidir_pipe.sv
// Single-port scratch RAM on a shared bidirectional data bus: byte-enable
// writes, pipelined reads with fixed latency, and a turnaround counter that
// holds off writes until the bus has been idle for TURN_CYC cycles after the
// block's last drive cycle.
module sp_mem_bidir_pipe
    import sp_mem_bidir_pipe_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int RD_LAT   = DEF_RD_LAT,
    parameter int TURN_CYC = DEF_TURN_CYC
) (
    input  logic                          i_clk,
    input  logic                          i_rst_n,
    input  logic                          i_req,
    input  logic                          i_we,
    input  logic [be_width(DATA_W)-1:0]   i_be,
    input  logic [ADDR_W-1:0]             i_addr,
    inout  wire  [DATA_W-1:0]             io_data,
    output logic                          o_wr_ready,
    output logic                          o_rvalid,
    output logic                          o_drop
);

    localparam int    BE_W      = be_width(DATA_W);
    localparam int    DEPTH     = 2 ** ADDR_W;
    localparam busy_t BUSY_LOAD = busy_t'(RD_LAT + TURN_CYC);

    if (!(data_w_ok(DATA_W) && rd_lat_ok(RD_LAT) && turn_cyc_ok(TURN_CYC))) begin : g_param_err
        $error("sp_mem_bidir_pipe: illegal DATA_W/RD_LAT/TURN_CYC");
    end

    logic [DATA_W-1:0] mem_q [DEPTH];
    busy_t             busy_q;
    busy_t             busy_d;
    logic              drop_q;
    logic              drop_d;
    logic              rd_acc_s;
    logic              wr_req_s;
    logic              wr_acc_s;
    logic [DATA_W-1:0] rd_word_s;
    logic              pipe_valid_s;
    logic [DATA_W-1:0] pipe_data_s;

    // Writes are held off while read data is pending or the bus is turning around.
    assign o_wr_ready = (busy_q == BUSY_ZERO);

    // Decode the request strobe into read / write intent.
    always_comb begin
        rd_acc_s = i_req & ~i_we;
        wr_req_s = i_req & i_we;
        wr_acc_s = i_req & i_we & o_wr_ready;
    end

    // Turnaround countdown and one-cycle-late drop flag.
    always_comb begin
        busy_d = busy_q;
        drop_d = 1'b0;
        if (rd_acc_s) begin
            busy_d = BUSY_LOAD;
        end else if (busy_q != BUSY_ZERO) begin
            busy_d = busy_q - BUSY_ONE;
        end else begin
            busy_d = BUSY_ZERO;
        end
        if (wr_req_s && !o_wr_ready) begin
            drop_d = 1'b1;
        end else begin
            drop_d = 1'b0;
        end
    end

    // Control state registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            busy_q <= BUSY_ZERO;
            drop_q <= 1'b0;
        end else begin
            busy_q <= busy_d;
            drop_q <= drop_d;
        end
    end

    // Byte-lane write into the array; contents survive reset.
    always_ff @(posedge i_clk) begin
        if (wr_acc_s) begin
            for (int b = 0; b < BE_W; b++) begin
                if (i_be[b]) begin
                    mem_q[i_addr][8*b +: 8] <= io_data[8*b +: 8];
                end
            end
        end
    end

    // Read sample happens in the accept cycle, so a write from the previous
    // cycle is already visible.
    assign rd_word_s = mem_q[i_addr];

    sp_mem_rd_pipe #(
        .DATA_W (DATA_W),
        .STAGES (RD_LAT)
    ) u_rd_pipe (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_valid (rd_acc_s),
        .i_data  (rd_word_s),
        .o_valid (pipe_valid_s),
        .o_data  (pipe_data_s)
    );

    assign o_rvalid = pipe_valid_s;
    assign o_drop   = drop_q;

    // Drive only in a read-return cycle; busy_q is non-zero then, so no write
    // can be accepted at the same time.
    assign io_data = pipe_valid_s ? pipe_data_s : {DATA_W{1'bz}};

endmodule

// File: tb/tb_sp_mem_bidir_pipe.sv
// Bench: table of per-cycle operations plus hand-written sequences for
// turnaround, TURN_CYC=0 and reset corner cases. Two instances share the
// request inputs: A uses TURN_CYC=1, B uses TURN_CYC=0; both RD_LAT=2.
module tb_sp_mem_bidir_pipe;

    localparam int DW = 16;
    localparam int AW = 10;
    localparam int RL = 2;
    localparam int TA = 1;
    localparam int TB = 0;

    localparam int OP_IDLE = 0;
    localparam int OP_WR   = 1;
    localparam int OP_RD   = 2;

    typedef struct {
        int          op;
        logic [1:0]  be;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [DW-1:0] exp;
    } vec_t;

    typedef struct {
        int            due;
        logic [DW-1:0] da;
        logic [DW-1:0] db;
    } rd_exp_t;

    logic          clk   = 1'b0;
    logic          rst_n = 1'b0;
    logic          req   = 1'b0;
    logic          we    = 1'b0;
    logic [1:0]    be    = 2'b00;
    logic [AW-1:0] addr  = '0;
    logic [DW-1:0] tb_data = '0;
    logic          drv_a = 1'b0;
    logic          drv_b = 1'b0;
    wire  [DW-1:0] bus_a;
    wire  [DW-1:0] bus_b;
    logic          rdy_a, rv_a, drop_a;
    logic          rdy_b, rv_b, drop_b;

    assign bus_a = drv_a ? tb_data : {DW{1'bz}};
    assign bus_b = drv_b ? tb_data : {DW{1'bz}};

    always #5 clk = ~clk;

    sp_mem_bidir_pipe #(.DATA_W(DW), .ADDR_W(AW), .RD_LAT(RL), .TURN_CYC(TA)) dut_a (
        .i_clk(clk), .i_rst_n(rst_n), .i_req(req), .i_we(we), .i_be(be),
        .i_addr(addr), .io_data(bus_a), .o_wr_ready(rdy_a), .o_rvalid(rv_a),
        .o_drop(drop_a)
    );

    sp_mem_bidir_pipe #(.DATA_W(DW), .ADDR_W(AW), .RD_LAT(RL), .TURN_CYC(TB)) dut_b (
        .i_clk(clk), .i_rst_n(rst_n), .i_req(req), .i_we(we), .i_be(be),
        .i_addr(addr), .io_data(bus_b), .o_wr_ready(rdy_b), .o_rvalid(rv_b),
        .o_drop(drop_b)
    );

    int      n_vec = 0;
    int      n_err = 0;
    int      cyc = 0;
    int      ready_at_a = 0;
    int      ready_at_b = 0;
    logic    rej_a = 1'b0;
    logic    rej_b = 1'b0;
    rd_exp_t sb[$];
    vec_t    tbl[$];

    task automatic chk1(input string name, input logic act, input logic exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s cyc=%0d: got %b expected %b", name, cyc, act, exp);
        end
    endtask

    task automatic chk16(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s cyc=%0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    task automatic add(input int op, input logic [1:0] b, input logic [AW-1:0] a,
                       input logic [DW-1:0] wd, input logic [DW-1:0] e);
        vec_t v;
        v.op = op; v.be = b; v.addr = a; v.wdata = wd; v.exp = e;
        tbl.push_back(v);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
        cyc++;
        req = 1'b0; we = 1'b0; drv_a = 1'b0; drv_b = 1'b0;
    endtask

    task automatic model_reset();
        sb.delete();
        ready_at_a = 0;
        ready_at_b = 0;
        rej_a = 1'b0;
        rej_b = 1'b0;
    endtask

    // Compare read-return outputs of this cycle against the scoreboard head.
    task automatic check_read();
        logic due;
        due = (sb.size() > 0) && (sb[0].due == cyc);
        chk1("rvalid_a", rv_a, due);
        chk1("rvalid_b", rv_b, due);
        if (due) begin
            chk16("rdata_a", bus_a, sb[0].da);
            chk16("rdata_b", bus_b, sb[0].db);
            void'(sb.pop_front());
        end
    endtask

    // Apply one operation for one cycle and check that cycle's outputs.
    task automatic run_cycle(input int op, input logic [1:0] b, input logic [AW-1:0] a,
                             input logic [DW-1:0] wd, input logic [DW-1:0] ea,
                             input logic [DW-1:0] eb);
        logic ok_a, ok_b;
        rd_exp_t e;
        ok_a = (cyc >= ready_at_a);
        ok_b = (cyc >= ready_at_b);
        req = (op != OP_IDLE); we = (op == OP_WR); be = b; addr = a; tb_data = wd;
        drv_a = (op == OP_WR) && ok_a;
        drv_b = (op == OP_WR) && ok_b;
        if (op == OP_RD) begin
            e.due = cyc + RL; e.da = ea; e.db = eb;
            sb.push_back(e);
            ready_at_a = cyc + RL + TA + 1;
            ready_at_b = cyc + RL + TB + 1;
        end
        @(negedge clk);
        chk1("wr_ready_a", rdy_a, ok_a);
        chk1("wr_ready_b", rdy_b, ok_b);
        chk1("drop_a", drop_a, rej_a);
        chk1("drop_b", drop_b, rej_b);
        check_read();
        rej_a = (op == OP_WR) && !ok_a;
        rej_b = (op == OP_WR) && !ok_b;
        next_cycle();
    endtask

    task automatic op1(input int op, input logic [1:0] b, input logic [AW-1:0] a,
                       input logic [DW-1:0] wd, input logic [DW-1:0] e);
        run_cycle(op, b, a, wd, e, e);
    endtask

    task automatic idles(input int n);
        for (int i = 0; i < n; i++) op1(OP_IDLE, 2'b00, '0, '0, '0);
    endtask

    initial begin
        // Reset state while held in reset.
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk1("rst_rvalid_a", rv_a, 1'b0);
        chk1("rst_rvalid_b", rv_b, 1'b0);
        chk1("rst_ready_a", rdy_a, 1'b1);
        chk1("rst_ready_b", rdy_b, 1'b1);
        chk1("rst_drop_a", drop_a, 1'b0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cyc = 0;

        // Table: byte enables, pipelined reads, read-after-write, be=0 no-op.
        add(OP_WR, 2'b11, 10'h010, 16'hA5A5, 16'h0000);
        add(OP_WR, 2'b10, 10'h010, 16'h3C00, 16'h0000);
        add(OP_RD, 2'b00, 10'h010, 16'h0000, 16'h3CA5);
        for (int i = 0; i < 4; i++) add(OP_IDLE, 2'b00, 10'h000, 16'h0000, 16'h0000);
        add(OP_WR, 2'b11, 10'h001, 16'h1111, 16'h0000);
        add(OP_WR, 2'b11, 10'h002, 16'h2222, 16'h0000);
        add(OP_WR, 2'b11, 10'h003, 16'h3333, 16'h0000);
        add(OP_WR, 2'b11, 10'h020, 16'h0F0F, 16'h0000);
        add(OP_RD, 2'b00, 10'h001, 16'h0000, 16'h1111);
        add(OP_RD, 2'b00, 10'h002, 16'h0000, 16'h2222);
        add(OP_RD, 2'b00, 10'h003, 16'h0000, 16'h3333);
        for (int i = 0; i < 4; i++) add(OP_IDLE, 2'b00, 10'h000, 16'h0000, 16'h0000);
        add(OP_WR, 2'b11, 10'h3FF, 16'hBEEF, 16'h0000);
        add(OP_RD, 2'b00, 10'h3FF, 16'h0000, 16'hBEEF);
        for (int i = 0; i < 4; i++) add(OP_IDLE, 2'b00, 10'h000, 16'h0000, 16'h0000);
        add(OP_WR, 2'b00, 10'h001, 16'hFFFF, 16'h0000);
        add(OP_WR, 2'b01, 10'h002, 16'h00AB, 16'h0000);
        add(OP_RD, 2'b00, 10'h001, 16'h0000, 16'h1111);
        add(OP_RD, 2'b00, 10'h002, 16'h0000, 16'h22AB);
        for (int i = 0; i < 4; i++) add(OP_IDLE, 2'b00, 10'h000, 16'h0000, 16'h0000);
        foreach (tbl[i]) op1(tbl[i].op, tbl[i].be, tbl[i].addr, tbl[i].wdata, tbl[i].exp);

        // Turnaround and drop: read at T, write attempts from T+1.
        op1(OP_RD, 2'b00, 10'h010, 16'h0000, 16'h3CA5);
        for (int i = 0; i < 4; i++) op1(OP_WR, 2'b11, 10'h100, 16'h7777, 16'h0000);
        idles(1);
        op1(OP_RD, 2'b00, 10'h100, 16'h0000, 16'h7777);
        idles(4);

        // TURN_CYC=0: B accepts the write at T+3, A rejects it.
        op1(OP_RD, 2'b00, 10'h010, 16'h0000, 16'h3CA5);
        idles(2);
        op1(OP_WR, 2'b11, 10'h020, 16'h1234, 16'h0000);
        idles(1);
        run_cycle(OP_RD, 2'b00, 10'h020, 16'h0000, 16'h0F0F, 16'h1234);
        idles(4);

        // Reset asserted in the cycle after a read: read must never appear.
        op1(OP_RD, 2'b00, 10'h3FF, 16'h0000, 16'hBEEF);
        rst_n = 1'b0;
        #1;
        chk1("rstmid_rvalid_a", rv_a, 1'b0);
        chk1("rstmid_ready_a", rdy_a, 1'b1);
        model_reset();
        @(negedge clk);
        chk1("rstmid_t1_rvalid_a", rv_a, 1'b0);
        next_cycle();
        @(negedge clk);
        chk1("rstmid_t2_rvalid_a", rv_a, 1'b0);
        chk1("rstmid_t2_rvalid_b", rv_b, 1'b0);
        chk1("rstmid_t2_drop_a", drop_a, 1'b0);
        next_cycle();
        rst_n = 1'b1;
        idles(1);
        op1(OP_RD, 2'b00, 10'h001, 16'h0000, 16'h1111);
        op1(OP_RD, 2'b00, 10'h3FF, 16'h0000, 16'hBEEF);
        op1(OP_RD, 2'b00, 10'h010, 16'h0000, 16'h3CA5);
        idles(4);

        // Reset asserted in the drive cycle releases the bus at once.
        op1(OP_RD, 2'b00, 10'h001, 16'h0000, 16'h1111);
        idles(1);
        #1;
        chk1("drive_rvalid_a", rv_a, 1'b1);
        chk16("drive_rdata_a", bus_a, 16'h1111);
        rst_n = 1'b0;
        #1;
        chk1("async_rvalid_a", rv_a, 1'b0);
        chk1("async_rvalid_b", rv_b, 1'b0);
        model_reset();
        next_cycle();
        rst_n = 1'b1;
        idles(1);
        op1(OP_RD, 2'b00, 10'h002, 16'h0000, 16'h22AB);
        idles(4);

        chk1("scoreboard_empty", (sb.size() == 0), 1'b1);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/sp_mem_bidir_pipe.md
Name: sp_mem_bidir_pipe

Overview:
Parametrised single-port RAM with a shared bidirectional data bus. It generalises width and depth, and adds byte-enable writes, a configurable read latency and enforced bus-turnaround cycles. A write-ready handshake stops the external master from driving the bus while the block is driving it. Local scratch memory for bus-based masters in the basics/memory set.

Parameters:
DATA_W, 16, data bus width in bits; must be a multiple of 8
ADDR_W, 10, address width; depth = 2**ADDR_W words
RD_LAT, 1, cycles from read acceptance to data on bus; legal range 1..4
TURN_CYC, 1, idle (undriven) cycles forced between the block's last drive cycle and the next write acceptance; legal range 0..3

Ports:
i_clk  input  1  sole clock, rising edge
i_rst_n  input  1  reset, asynchronous assert, active-low
i_req  input  1  request strobe, one request per cycle
i_we  input  1  1 = write, 0 = read; qualified by i_req
i_be  input  DATA_W/8  byte enables for writes; bit n covers data[8n+7:8n]
i_addr  input  ADDR_W  word address
io_data  inout  DATA_W  shared data bus; high-Z unless the block is driving read data
o_wr_ready  output  1  1 = a write request this cycle is accepted
o_rvalid  output  1  1 = io_data carries read data this cycle
o_drop  output  1  one-cycle pulse: a write request was rejected

Behaviour:
- Reset and clocking: one clock; reset is asynchronous and active-low. While i_rst_n=0, or immediately on its assertion: o_rvalid=0, io_data=Z, o_drop=0, o_wr_ready=1, read pipeline valids cleared, turnaround counter=0. Memory contents are not reset.
- Reads: i_req=1 and i_we=0 is always accepted, including back-to-back and while earlier reads are in flight.
  - A read accepted in cycle T drives mem[i_addr] on io_data for exactly cycle T+RD_LAT, with o_rvalid=1 in that cycle. Otherwise io_data=Z.
  - Fully pipelined: N consecutive reads give N consecutive drive cycles, in request order.
- Writes: i_req=1 and i_we=1 with o_wr_ready=1 writes io_data into mem[i_addr] at the end of that cycle, updating only the bytes whose i_be bit is 1. i_be=0 is a legal no-op.
- Turnaround counter busy_cnt:
  - Loaded with RD_LAT+TURN_CYC at each read acceptance; otherwise decrements to 0.
  - o_wr_ready = (busy_cnt==0), combinational from the register.
  - After the last drive cycle, exactly TURN_CYC cycles pass with io_data=Z before a write can be accepted.
- Rejected write: i_req=1, i_we=1, o_wr_ready=0 → write dropped, memory unchanged, o_drop=1 in the following cycle. Read acceptance is unaffected.
- Read-after-write: a read of the same address in the cycle after a write returns the newly written data (write commits before the next read sample).
- Reset mid-operation: in-flight reads are discarded and never driven. The bus is released asynchronously. The first read after reset release behaves as from idle.
- Contention guarantee: the block never drives io_data in a cycle where it accepts a write.
- Address wraps naturally at 2**ADDR_W; no out-of-range detection.

Decomposition:
- Shared package: default DATA_W/ADDR_W/RD_LAT/TURN_CYC constants, the byte-enable width function (DATA_W/8), and the legal-range checks.
- One sub-module, sp_mem_rd_pipe: RD_LAT-stage valid+data shift register with async active-low clear. The top level holds the memory array, byte-enable write, busy_cnt and the tristate.

Test Plan:
- Byte-enable write: parameters DATA_W=16, RD_LAT=2, TURN_CYC=1. Write 0xA5A5 to addr 0x010, be=11; write 0x3C00 to addr 0x010, be=10; read 0x010 at T → io_data=0x3CA5, o_rvalid=1 only in T+2; Z at T+1 and T+3.
- Pipelined reads: reads to 0x001, 0x002, 0x003 in T..T+2 (preloaded 0x1111/0x2222/0x3333) → drives 0x1111, 0x2222, 0x3333 in T+2..T+4, o_rvalid high for exactly 3 cycles.
- Turnaround and drop: single read at T; write attempts every cycle from T+1.
  - Expect o_wr_ready=0 for T+1..T+3 and o_drop pulses in T+2..T+4.
  - First write accepted at T+4; io_data=Z in T+3.
- Read-after-write: write 0xBEEF to 0x3FF at T, read 0x3FF at T+1 → 0xBEEF driven at T+3.
- Reset mid-read: read at T, assert i_rst_n=0 in T+1 → io_data=Z and o_rvalid=0 immediately and through T+3. After release, memory still holds pre-reset data.
- TURN_CYC=0 variant: read at T → write accepted at T+3, immediately after the drive cycle at T+2.
